// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch stage.
package mips_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  // Default fetch address after reset.
  localparam logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000;

  // One prefetch queue entry: the instruction word and the address it came from.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Next sequential instruction address; wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] next_word_addr(input logic [WORD_W-1:0] a);
    return a + WORD_W'(INSTR_BYTES);
  endfunction

  // Force an address onto a word boundary.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit and memory.
interface instr_fetch_unit_if;
  import mips_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [WORD_W-1:0] req_addr;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_data;

  // Fetch unit side: issues addresses, receives instruction words.
  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  // Memory side.
  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO: DEPTH entries, wrap-around pointers, flush beats push and pop.
module fetch_queue
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_push,
  input  fetch_entry_t     i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_count,
  output fetch_entry_t     o_head
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;
  logic             w_empty;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign w_empty   = (r_count == {CNT_W{1'b0}});
  assign w_do_pop  = i_pop && !w_empty;
  // A push into a full queue is only legal when a pop frees the slot.
  assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{instr: 32'h0000_0000, pc: 32'h0000_0000};
      end
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  assign o_count = r_count;
  // Head is purely a register read; empty queue presents zeros.
  assign o_head  = w_empty ? '{instr: 32'h0000_0000, pc: 32'h0000_0000} : r_mem[r_rd_ptr];

endmodule

// File: rtl/instr_fetch_unit_chk.sv
// Invariant checker for the fetch unit's credit and drop accounting.
module instr_fetch_unit_chk #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             reset_n,
  input logic             i_push,
  input logic             i_pop,
  input logic             i_flush,
  input logic [CNT_W-1:0] i_count,
  input logic [CNT_W-1:0] i_outstanding,
  input logic [CNT_W-1:0] i_drop_cnt
);

  a_no_push_full: assert property (@(posedge clk) disable iff (!reset_n)
    (i_push && !i_pop && !i_flush) |-> (i_count != CNT_W'(DEPTH)));

  a_credit: assert property (@(posedge clk) disable iff (!reset_n)
    (({1'b0, i_outstanding} + {1'b0, i_count}) <= (CNT_W + 1)'(DEPTH)));

  a_drop_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (i_drop_cnt <= i_outstanding));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential address generation, credit-limited memory requests,
// in-order response buffering, and redirect with stale-response dropping.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  instr_fetch_unit_if.master        imem,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr,
  output logic [31:0]               instr_pc,
  output logic [31:0]               instr_pcplus4
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  logic             w_issue_en;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [31:0]      w_target;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_head;
  fetch_entry_t     w_push_data;
  logic             w_credit_ok;
  logic             w_req_valid;
  logic             w_req_fire;
  logic             w_rsp_take;
  logic             w_push;
  logic             w_pop;
  logic             w_instr_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: BOOT lasts a single idle cycle, FETCH holds until reset.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_en  = 1'b0;
    case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
        w_issue_en  = 1'b0;
      end
      FETCH: begin
        w_state_nxt = FETCH;
        w_issue_en  = 1'b1;
      end
      default: begin
        w_state_nxt = BOOT;
        w_issue_en  = 1'b0;
      end
    endcase
  end

  assign w_target    = align_word(redirect_pc);
  // Requests in flight plus buffered entries never exceed the queue size,
  // so every response has a slot waiting for it.
  assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_count}) < (CNT_W + 1)'(DEPTH);
  assign w_req_valid = w_issue_en && w_credit_ok && !redirect_valid;
  assign w_req_fire  = w_req_valid && imem.req_ready;
  // Ignore responses with nothing outstanding (leftovers from before a reset).
  assign w_rsp_take  = imem.rsp_valid && (r_outstanding != {CNT_W{1'b0}});
  assign w_push      = w_rsp_take && (r_drop_cnt == {CNT_W{1'b0}}) && !redirect_valid;
  assign w_instr_valid = (w_count != {CNT_W{1'b0}});
  assign w_pop       = w_instr_valid && instr_ready && !redirect_valid;
  assign w_push_data = '{instr: imem.rsp_data, pc: r_resp_pc};

  // Fetch/response pointers and outstanding/drop accounting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= {CNT_W{1'b0}};
      r_drop_cnt    <= {CNT_W{1'b0}};
    end else if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path.
      r_fetch_pc    <= w_target;
      r_resp_pc     <= w_target;
      r_outstanding <= r_outstanding - CNT_W'(w_rsp_take);
      r_drop_cnt    <= r_outstanding - CNT_W'(w_rsp_take);
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= next_word_addr(r_fetch_pc);
      end
      if (w_push) begin
        r_resp_pc <= next_word_addr(r_resp_pc);
      end
      r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_take);
      if (w_rsp_take && (r_drop_cnt != {CNT_W{1'b0}})) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  instr_fetch_unit_chk #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chk (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_push        (w_push),
    .i_pop         (w_pop),
    .i_flush       (redirect_valid),
    .i_count       (w_count),
    .i_outstanding (r_outstanding),
    .i_drop_cnt    (r_drop_cnt)
  );

  assign imem.req_valid = w_req_valid;
  assign imem.req_addr  = r_fetch_pc;
  assign instr_valid    = w_instr_valid;
  assign instr          = w_head.instr;
  assign instr_pc       = w_head.pc;
  assign instr_pcplus4  = w_instr_valid ? next_word_addr(w_head.pc) : 32'h0000_0000;

endmodule
